// File: rtl/fact_seq_if.sv
// Bus bundle between the factorial accelerator's register block and its sequencer.
// The register block is the master: it drives the operand and the start pulse.
interface fact_seq_if;
    logic        go;
    logic [3:0]  n;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    modport master (output go, output n, input busy, input done, input err, input result);
    modport slave  (input go, input n, output busy, output done, output err, output result);
endinterface

// File: rtl/fact_seq.sv
// Iterative n! engine: one 32x4 multiply per cycle, sticky done/err flags and a
// result register that only changes when a computation completes.
//
//   state  | meaning
//   IDLE   | waiting for go; done/err/result hold the last outcome
//   LOAD   | operand latched; range check and trivial 0!/1! cases
//   MUL    | prod *= cnt, cnt--, finish when cnt reaches 2
module fact_seq #(
    parameter int NMAX = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    fact_seq_if.slave bus
);

    localparam int unsigned NMAX_U = NMAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_prod;
    logic [31:0] r_result;
    logic        r_done;
    logic        r_err;
    logic        w_busy;
    logic        w_over;
    logic        w_last;
    logic [31:0] w_prod_mul;

    assign w_over     = 32'(r_cnt) > NMAX_U;
    assign w_last     = (r_cnt == 4'd2);
    assign w_prod_mul = r_prod * {28'd0, r_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_over || (r_cnt <= 4'd1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // go seen outside IDLE is deliberately ignored; operand is only captured here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 4'd0;
            r_prod   <= 32'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_cnt  <= bus.n;
                        r_prod <= 32'd1;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_over) begin
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_result <= 32'd0;
                    end else if (r_cnt <= 4'd1) begin
                        r_result <= 32'd1;
                        r_done   <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod_mul;
                    r_cnt  <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_result <= w_prod_mul;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule

// File: tb/tb_fact_seq.sv
// Bench for fact_seq: directed scenarios plus randomized operands, checked against
// a plain-arithmetic factorial/latency model.
module tb_fact_seq;

    localparam int NMAX = 12;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    logic [31:0] last_res;

    fact_seq_if bus ();

    fact_seq #(.NMAX(NMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fact(input int nv);
        longint acc;
        acc = 1;
        for (int i = 2; i <= nv; i++) acc = acc * i;
        return acc[31:0];
    endfunction

    // Called just after an edge: issues go, then walks through the expected latency.
    task automatic run_op(input int nv, input bit poke);
        int          lat;
        bit          e;
        logic [31:0] exp;
        e   = (nv > NMAX);
        exp = e ? 32'd0 : fact(nv);
        lat = (e || nv <= 1) ? 1 : nv;
        bus.go = 1'b1;
        bus.n  = 4'(nv);
        @(posedge clk); #1;
        bus.go = 1'b0;
        bus.n  = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            chk("busy_run", {31'd0, bus.busy}, 32'd1);
            chk("done_clr", {31'd0, bus.done}, 32'd0);
            chk("err_clr", {31'd0, bus.err}, 32'd0);
            chk("res_hold", bus.result, last_res);
            if (poke && k == 2) begin
                bus.go = 1'b1;
                bus.n  = 4'd2;
            end
            @(posedge clk); #1;
            bus.go = 1'b0;
        end
        chk("busy_end", {31'd0, bus.busy}, 32'd0);
        chk("done_set", {31'd0, bus.done}, 32'd1);
        chk("err_val", {31'd0, bus.err}, {31'd0, e});
        chk("result", bus.result, exp);
        last_res = exp;
    endtask

    initial begin
        int nv;
        int gap;
        n_total  = 0;
        n_bad    = 0;
        last_res = 32'd0;
        bus.go   = 1'b0;
        bus.n    = 4'd0;
        rst_n    = 1'b0;
        #23;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_res", bus.result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(5, 1'b0);
        run_op(0, 1'b0);
        run_op(1, 1'b0);
        run_op(12, 1'b0);
        run_op(13, 1'b0);
        run_op(15, 1'b0);
        run_op(3, 1'b0);
        run_op(6, 1'b1);

        // Reset half a cycle after E4 of an n=10 run.
        bus.go = 1'b1;
        bus.n  = 4'd10;
        @(posedge clk); #1;
        bus.go = 1'b0;
        repeat (4) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
        chk("mid_rst_res", bus.result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_res = 32'd0;
        @(posedge clk); #1;
        run_op(4, 1'b0);

        // go held high with n=3: period of 4 edges, done visible one cycle.
        bus.go = 1'b1;
        bus.n  = 4'd3;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #1;
            chk("cont_done", {31'd0, bus.done}, {31'd0, (j % 4) == 3});
            chk("cont_busy", {31'd0, bus.busy}, {31'd0, (j % 4) != 3});
            if (j >= 3) chk("cont_res", bus.result, 32'd6);
        end
        bus.go = 1'b0;
        @(posedge clk); #1;
        last_res = 32'd6;
        // Drain the op that the held go may have started.
        for (int j = 0; j < 4 && bus.busy; j++) begin
            @(posedge clk); #1;
        end
        chk("drain_idle", {31'd0, bus.busy}, 32'd0);

        for (int t = 0; t < 25; t++) begin
            nv  = $urandom_range(0, 15);
            gap = $urandom_range(0, 3);
            run_op(nv, 1'($urandom));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                chk("gap_done", {31'd0, bus.done}, 32'd1);
                chk("gap_res", bus.result, last_res);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
